// File: rtl/sram_trk_pkg.sv
// Shared sizing helpers and default widths for the SRAM in-flight tracker.
package sram_trk_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a depth-entry ring; at least one bit.
  function automatic int ptr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sram_inflight_tracker_chk.sv
// Protocol checker for the in-flight tracker: response ordering and FIFO bounds.
module sram_inflight_tracker_chk #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sram_data_ok,
  input  logic [CNT_W-1:0] out_cnt,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_W-1:0] fifo_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  // A data_ok with nothing outstanding has no request to belong to.
  a_no_unmatched_data_ok: assert property (
    @(posedge clk) disable iff (reset) sram_data_ok |-> (out_cnt != CNT_ZERO)
  );

  // Credit accounting must keep the response buffer from overflowing.
  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (reset) (push && !pop) |-> (fifo_cnt < DEPTH_C)
  );

endmodule

// File: rtl/sram_inflight_tracker_resp_fifo.sv
// Synchronous response FIFO (DEPTH x DATA_W) with push/pop/clear and occupancy.
// Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
module resp_fifo
  import sram_trk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  // Pointer and occupancy state; clear wins over any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else if (clear) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Data storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = cnt_r;
  assign empty     = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/sram_inflight_tracker.sv
// Outstanding-request tracker for an SRAM-like req/addr_ok/data_ok bus.
// Issues up to DEPTH requests (in flight + buffered), buffers read data in
// order, and on flush discards every response still owed to the old stream.
// Optional macro SRAM_TRACKER_BYPASS_EN: when nothing is buffered or owed,
// returning data is presented to the consumer in the same cycle.
module sram_inflight_tracker
  import sram_trk_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    up_req,
  input  logic [ADDR_W-1:0]       up_addr,
  output logic                    up_accept,
  output logic                    sram_req,
  output logic [ADDR_W-1:0]       sram_addr,
  input  logic                    sram_addr_ok,
  input  logic [DATA_W-1:0]       sram_rdata,
  input  logic                    sram_data_ok,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    rsp_ready,
  output logic [cnt_w(DEPTH)-1:0] out_cnt,
  output logic                    idle
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]  out_cnt_r;
  logic [CNT_W-1:0]  discard_cnt_r;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              credit_ok_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
`ifdef SRAM_TRACKER_BYPASS_EN
  logic              byp_s;
`endif

  // Request path: issue only with a free slot, never during flush or reset.
  always_comb begin
    credit_ok_s = (({1'b0, out_cnt_r} + {1'b0, fifo_cnt_s}) < DEPTH_EXT);
    sram_req    = up_req && credit_ok_s && !flush && !reset;
    up_accept   = sram_req && sram_addr_ok;
    sram_addr   = up_addr;
  end

  // Response path: drop stale data, buffer live data, present the head.
  always_comb begin
    drop_s    = sram_data_ok && (discard_cnt_r != CNT_ZERO);
    push_s    = !flush && sram_data_ok && (discard_cnt_r == CNT_ZERO);
    pop_s     = !flush && rsp_ready && !fifo_empty_s;
    rsp_valid = !fifo_empty_s;
    rsp_data  = fifo_head_s;
`ifdef SRAM_TRACKER_BYPASS_EN
    byp_s = fifo_empty_s && push_s;
    if (byp_s) begin
      rsp_valid = 1'b1;
      rsp_data  = sram_rdata;
      push_s    = !rsp_ready;
    end else begin
      rsp_valid = !fifo_empty_s;
      rsp_data  = fifo_head_s;
    end
`endif
  end

  // Outstanding and discard counters; flush re-derives the discard count
  // from out_cnt, which already includes any pending discards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt_r     <= CNT_ZERO;
      discard_cnt_r <= CNT_ZERO;
    end else begin
      out_cnt_r <= out_cnt_r + CNT_W'(up_accept) - CNT_W'(sram_data_ok);
      if (flush) begin
        discard_cnt_r <= out_cnt_r - CNT_W'(sram_data_ok);
      end else if (drop_s) begin
        discard_cnt_r <= discard_cnt_r - CNT_W'(1'b1);
      end else begin
        discard_cnt_r <= discard_cnt_r;
      end
    end
  end

  assign out_cnt = out_cnt_r;
  assign idle    = (out_cnt_r == CNT_ZERO) && fifo_empty_s && (discard_cnt_r == CNT_ZERO);

  resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_s),
    .push_data (sram_rdata),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .count     (fifo_cnt_s),
    .empty     (fifo_empty_s)
  );

  sram_inflight_tracker_chk #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .sram_data_ok (sram_data_ok),
    .out_cnt      (out_cnt_r),
    .push         (push_s),
    .pop          (pop_s),
    .fifo_cnt     (fifo_cnt_s)
  );

endmodule

// File: tb/tb_sram_inflight_tracker.sv
// Self-checking bench for sram_inflight_tracker: queue-based reference model
// compared every cycle, plus literal expectations per directed scenario.
`timescale 1ns/1ps
module tb_sram_inflight_tracker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              up_req = 1'b0;
  logic [ADDR_W-1:0] up_addr = '0;
  logic              up_accept;
  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_addr_ok = 1'b0;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              sram_data_ok = 1'b0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready = 1'b0;
  logic [CNT_W-1:0]  out_cnt;
  logic              idle;

  always #5 clk = ~clk;

  sram_inflight_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .up_req(up_req), .up_addr(up_addr),
    .up_accept(up_accept), .sram_req(sram_req), .sram_addr(sram_addr),
    .sram_addr_ok(sram_addr_ok), .sram_rdata(sram_rdata), .sram_data_ok(sram_data_ok),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .out_cnt(out_cnt), .idle(idle)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: outstanding count, owed discards, buffered responses.
  int                m_out  = 0;
  int                m_disc = 0;
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] got[$];
  int                peak_out = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_out  = 0;
    m_disc = 0;
    m_fifo.delete();
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic model_step();
    int acc;
    int dok;
    int byp;
    bit do_pop;
    if (reset) begin
      model_reset();
      return;
    end
    acc = (up_req && ((m_out + m_fifo.size()) < DEPTH) && !flush && sram_addr_ok) ? 1 : 0;
    dok = sram_data_ok ? 1 : 0;
    if (flush) begin
      m_fifo.delete();
      m_disc = m_out - dok;
    end else begin
      do_pop = rsp_ready && (m_fifo.size() > 0);
      byp = 0;
`ifdef SRAM_TRACKER_BYPASS_EN
      byp = (m_fifo.size() == 0 && m_disc == 0 && dok == 1 && rsp_ready) ? 1 : 0;
`endif
      if (do_pop) void'(m_fifo.pop_front());
      if (dok == 1) begin
        if (m_disc > 0) m_disc--;
        else if (byp == 0) m_fifo.push_back(sram_rdata);
      end
    end
    m_out = m_out + acc - dok;
  endtask

  // Compare process: every output against the model, mid-cycle.
  initial begin
    logic              e_req;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    forever begin
      @(negedge clk);
      e_req   = up_req && ((m_out + m_fifo.size()) < DEPTH) && !flush && !reset;
      e_valid = (m_fifo.size() > 0);
      e_data  = (m_fifo.size() > 0) ? m_fifo[0] : '0;
`ifdef SRAM_TRACKER_BYPASS_EN
      if (m_fifo.size() == 0 && m_disc == 0 && !flush && sram_data_ok && !reset) begin
        e_valid = 1'b1;
        e_data  = sram_rdata;
      end
`endif
      check("cmp_sram_req", sram_req, e_req);
      check("cmp_up_accept", up_accept, e_req && sram_addr_ok);
      check("cmp_sram_addr", sram_addr, up_addr);
      check("cmp_rsp_valid", rsp_valid, e_valid);
      if (e_valid) check("cmp_rsp_data", rsp_data, e_data);
      check("cmp_out_cnt", out_cnt, m_out);
      check("cmp_idle", idle, (m_out == 0 && m_fifo.size() == 0 && m_disc == 0));
      if (rsp_valid && rsp_ready && !flush && !reset) got.push_back(rsp_data);
      if (int'(out_cnt) > peak_out) peak_out = int'(out_cnt);
    end
  end

  task automatic drive(input logic req, input logic [31:0] a, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic rdy, input logic fl);
    up_req = req; up_addr = a; sram_addr_ok = aok;
    sram_data_ok = dok; sram_rdata = rd; rsp_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    // Reset state, with a pending upstream request that must not leak out.
    up_req = 1'b1;
    #2;
    check("rst_out_cnt", out_cnt, 0);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sram_req", sram_req, 0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // 1: six back-to-back requests, data two cycles later, consumer ready.
    got.delete(); peak_out = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 6, 32'(32'h1000 + k * 4), 1'b1, (k >= 2 && k < 8), 32'(32'hA0 + k - 2), 1'b1, 1'b0);
      tick();
    end
    check("t1_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("t1_data", got[i], 32'(32'hA0 + i));
    check("t1_peak_out", peak_out, 2);

    // 2: credit limit with a stalled consumer.
    got.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h2000 + i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2010, 1'b1, 1'b1, 32'(32'hC0 + i), 1'b0, 1'b0);
      if (i == 0) begin
        #1 check("t2_req_blocked_at_depth", sram_req, 0);
      end
      tick();
    end
    check("t2_out_cnt_zero", out_cnt, 0);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_head", rsp_data, 32'hC0);
    drive(1'b1, 32'h2010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1 check("t2_full_fifo_blocks", sram_req, 0);
    tick();
    drive(1'b1, 32'h2010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1 check("t2_fifth_accepted", up_accept, 1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hC4, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check("t2_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("t2_data", got[i], 32'(32'hC0 + i));
    check("t2_idle", idle, 1);

    // 3: flush with a same-cycle data_ok, then a fresh request.
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h3000 + i * 4), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h3100, 1'b1, 1'b1, 32'hDEAD0001, 1'b1, 1'b1);
    #1 check("t3_no_req_in_flush", sram_req, 0);
    tick();
    drive(1'b1, 32'h3100, 1'b1, 1'b1, 32'hDEAD0002, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD0003, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000BEEF, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    check("t3_count", got.size(), 1);
    if (got.size() > 0) check("t3_beef", got[0], 32'h0000BEEF);
    check("t3_idle", idle, 1);

    // 4: flush with two buffered and one in flight, consumer stalled.
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h4000 + i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD1, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    check("t4_valid_after_flush", rsp_valid, 0);
    check("t4_not_idle", idle, 0);
    check("t4_out_cnt", out_cnt, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD2, 1'b1, 1'b0); tick();
    check("t4_idle", idle, 1);
    check("t4_valid", rsp_valid, 0);

    // 5: two flushes a cycle apart with one data_ok between them.
    got.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h5000 + i * 4), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hE0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'(32'hE0 + i), 1'b1, 1'b0);
      tick();
    end
    check("t5_idle_after_drops", idle, 1);
    drive(1'b1, 32'h5100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h00005A5A, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("t5_count", got.size(), 1);
    if (got.size() > 0) check("t5_data", got[0], 32'h00005A5A);

    // 6: asynchronous reset with three requests in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h6000 + i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    check("t6_pre_out_cnt", out_cnt, 3);
    drive(1'b1, 32'h600C, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_out_cnt", out_cnt, 0);
    check("t6_idle", idle, 1);
    check("t6_sram_req", sram_req, 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("t6_idle_after", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
